// File: rtl/load_writeback.sv
// Multi-cycle load unit: issues one word read on a waitrequest-style data bus,
// then extracts/extends/merges the returned word into a single register-file write.
module load_writeback #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [2:0]        funct_i,
  input  logic [ADDR_W-1:0] dest_i,
  input  logic [1:0]        byte_off_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              mem_waitrequest_i,
  input  logic [DATA_W-1:0] mem_readdata_i,
  output logic              mem_read_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_3_o,
  output logic [DATA_W-1:0] write_data_3_o,
  output logic              write_enable_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

  typedef enum logic [2:0] {
    F_LB  = 3'd0,
    F_LBU = 3'd1,
    F_LH  = 3'd2,
    F_LHU = 3'd3,
    F_LW  = 3'd4,
    F_LWL = 3'd5,
    F_LWR = 3'd6,
    F_INV = 3'd7
  } funct_t;

  state_t              state, state_n;
  funct_t              funct_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [1:0]          off_q;
  logic [DATA_W-1:0]   rt_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   result;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      funct_q <= F_LB;
      dest_q  <= '0;
      off_q   <= '0;
      rt_q    <= '0;
      data_q  <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start_i) begin
        funct_q <= funct_t'(funct_i);
        dest_q  <= dest_i;
        off_q   <= byte_off_i;
        rt_q    <= rt_data_i;
      end
      if (state == S_REQ && !mem_waitrequest_i) begin
        data_q <= mem_readdata_i;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statements can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start_i) state_n = S_REQ;
      S_REQ:   if (!mem_waitrequest_i) state_n = S_WRITE;
      S_WRITE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Lane extraction works from the captured word only, never from the bus.
  always_comb begin
    byte_v = data_q[7:0];
    unique case (off_q)
      2'd0: byte_v = data_q[7:0];
      2'd1: byte_v = data_q[15:8];
      2'd2: byte_v = data_q[23:16];
      2'd3: byte_v = data_q[31:24];
      default: byte_v = data_q[7:0];
    endcase
    half_v = off_q[1] ? data_q[31:16] : data_q[15:0];
  end

  // LWL/LWR: memory bytes fill one end of rt, the remaining rt bytes are kept.
  always_comb begin
    result = '0;
    unique case (funct_q)
      F_LB:  result = {{24{byte_v[7]}}, byte_v};
      F_LBU: result = {24'h0, byte_v};
      F_LH:  result = {{16{half_v[15]}}, half_v};
      F_LHU: result = {16'h0, half_v};
      F_LW:  result = data_q;
      F_LWL: begin
        unique case (off_q)
          2'd0: result = {data_q[7:0],  rt_q[23:0]};
          2'd1: result = {data_q[15:0], rt_q[15:0]};
          2'd2: result = {data_q[23:0], rt_q[7:0]};
          default: result = data_q;
        endcase
      end
      F_LWR: begin
        unique case (off_q)
          2'd1: result = {rt_q[31:24], data_q[31:8]};
          2'd2: result = {rt_q[31:16], data_q[31:16]};
          2'd3: result = {rt_q[31:8],  data_q[31:24]};
          default: result = data_q;
        endcase
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    mem_read_o     = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    addr_3_o       = '0;
    write_data_3_o = '0;
    write_enable_o = 1'b0;
    unique case (state)
      S_REQ: begin
        mem_read_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_WRITE: begin
        busy_o         = 1'b1;
        done_o         = 1'b1;
        addr_3_o       = dest_q;
        write_data_3_o = result;
        write_enable_o = (dest_q != '0) && (funct_q != F_INV);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_writeback.sv
// Scoreboard bench for load_writeback: directed loads push expected writes,
// a negedge monitor pops and compares on every done_o pulse.
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  funct_i;
  logic [4:0]  dest_i;
  logic [1:0]  byte_off_i;
  logic [31:0] rt_data_i;
  logic        mem_waitrequest_i;
  logic [31:0] mem_readdata_i;
  logic        mem_read_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  addr_3_o;
  logic [31:0] write_data_3_o;
  logic        write_enable_o;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  load_writeback dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .funct_i           (funct_i),
    .dest_i            (dest_i),
    .byte_off_i        (byte_off_i),
    .rt_data_i         (rt_data_i),
    .mem_waitrequest_i (mem_waitrequest_i),
    .mem_readdata_i    (mem_readdata_i),
    .mem_read_o        (mem_read_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .addr_3_o          (addr_3_o),
    .write_data_3_o    (write_data_3_o),
    .write_enable_o    (write_enable_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_addr", {27'h0, addr_3_o}, {27'h0, e.dest});
          check("wb_data", write_data_3_o, e.data);
          check("wb_we",   {31'h0, write_enable_o}, {31'h0, e.we});
        end
      end else if (write_enable_o) begin
        check("we_without_done", 32'd1, 32'd0);
      end
    end
  end

  // Issue one load and follow it to the IDLE cycle after WRITE.
  task automatic run_load(input logic [2:0] f, input logic [4:0] d, input logic [1:0] k,
                          input logic [31:0] r, input logic [31:0] m, input int stall,
                          input logic [31:0] exp_data, input logic exp_we);
    int reads;
    exp_t e;
    e.dest = d; e.data = exp_data; e.we = exp_we;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b1; funct_i = f; dest_i = d; byte_off_i = k; rt_data_i = r;
    mem_readdata_i = 32'h0; mem_waitrequest_i = (stall > 0);
    @(negedge clk);
    start_i = 1'b0;
    mem_readdata_i = m;
    reads = 0;
    for (int i = 0; i < stall; i++) begin
      reads += int'(mem_read_o);
      @(negedge clk);
    end
    mem_waitrequest_i = 1'b0;
    check("read_at_n1", {31'h0, mem_read_o}, 32'd1);
    reads += int'(mem_read_o);
    @(negedge clk);
    mem_readdata_i = 32'hBADBAD00;
    check("done_at_n2", {31'h0, done_o}, 32'd1);
    if (stall > 0) check("read_cycles", reads, stall + 1);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done_o}, 32'd0);
    check("idle_not_busy",  {31'h0, busy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; funct_i = 3'd0; dest_i = 5'd0; byte_off_i = 2'd0;
    rt_data_i = 32'h0; mem_waitrequest_i = 1'b0; mem_readdata_i = 32'h0;
    #1;
    check("rst_mem_read", {31'h0, mem_read_o}, 32'd0);
    check("rst_outputs", {busy_o, done_o, write_enable_o, addr_3_o, write_data_3_o[23:0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("idle_outputs", {mem_read_o, busy_o, done_o, write_enable_o, addr_3_o, write_data_3_o[22:0]}, 32'd0);

    // Reset mid-REQ: stalled LW is abandoned, no write appears.
    start_i = 1'b1; funct_i = 3'd4; dest_i = 5'd7; mem_waitrequest_i = 1'b1;
    mem_readdata_i = 32'h12345678;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("req_held", {31'h0, mem_read_o}, 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("async_drop_read", {31'h0, mem_read_o}, 32'd0);
    check("async_drop_busy", {31'h0, busy_o}, 32'd0);
    check("async_drop_we",   {31'h0, write_enable_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0; mem_waitrequest_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {29'h0, mem_read_o, busy_o, done_o}, 32'd0);
    end

    // Byte / halfword / word loads.
    run_load(3'd0, 5'd5,  2'd2, 32'h0,        32'h12803456, 0, 32'hFFFFFF80, 1'b1);
    run_load(3'd1, 5'd5,  2'd2, 32'h0,        32'h12803456, 0, 32'h00000080, 1'b1);
    run_load(3'd0, 5'd6,  2'd0, 32'h0,        32'h12803456, 0, 32'h00000056, 1'b1);
    run_load(3'd2, 5'd9,  2'd3, 32'h0,        32'h80017FFF, 4, 32'hFFFF8001, 1'b1);
    run_load(3'd3, 5'd10, 2'd1, 32'h0,        32'h80018FFF, 1, 32'h00008FFF, 1'b1);
    run_load(3'd4, 5'd31, 2'd2, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b1);

    // Unaligned merges.
    run_load(3'd5, 5'd12, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 32'h3344CCDD, 1'b1);
    run_load(3'd5, 5'd12, 2'd3, 32'hAABBCCDD, 32'h11223344, 0, 32'h11223344, 1'b1);
    run_load(3'd6, 5'd13, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 32'hAA112233, 1'b1);
    run_load(3'd6, 5'd13, 2'd0, 32'hAABBCCDD, 32'h11223344, 2, 32'h11223344, 1'b1);

    // No-write cases: dest=0 and invalid funct still pulse done.
    run_load(3'd4, 5'd0, 2'd0, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0);
    run_load(3'd7, 5'd4, 2'd0, 32'h0, 32'hDEADBEEF, 0, 32'h00000000, 1'b0);

    // start_i held high: one transaction, next one from the following IDLE.
    exp_q.push_back('{dest: 5'd3, data: 32'h0000AAAA, we: 1'b1});
    exp_q.push_back('{dest: 5'd3, data: 32'h0000BBBB, we: 1'b1});
    @(negedge clk);
    start_i = 1'b1; funct_i = 3'd4; dest_i = 5'd3; byte_off_i = 2'd0;
    mem_waitrequest_i = 1'b0; mem_readdata_i = 32'h0000AAAA;
    @(negedge clk);
    check("hold_req", {31'h0, mem_read_o}, 32'd1);
    @(negedge clk);
    check("hold_write", {31'h0, done_o}, 32'd1);
    mem_readdata_i = 32'h0000BBBB;
    @(negedge clk);
    check("hold_idle_gap", {30'h0, mem_read_o, busy_o}, 32'd0);
    @(negedge clk);
    check("hold_second_req", {31'h0, mem_read_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    check("hold_second_done", {31'h0, done_o}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("hold_quiet", {29'h0, mem_read_o, busy_o, done_o}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
